// File: rtl/grader_pkg.sv
// Shared types and sizing helpers for the Znarly/Zood guess grader.
package grader_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, EXACT, SCAN, DONE} state_e;

  localparam int DEF_NUM_SLOTS  = 4;
  localparam int DEF_SHAPE_W    = 3;
  localparam int DEF_MAX_ROUNDS = 8;

  typedef logic [DEF_SHAPE_W-1:0] shape_t;

  // Bits needed to hold any value 0..n inclusive.
  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/unused_match_finder.sv
// Finds the lowest master slot that still holds the given shape and is not yet claimed.
module unused_match_finder #(
  parameter int NUM_SLOTS = 4,
  parameter int SHAPE_W   = 3
) (
  input  logic [SHAPE_W-1:0]           shape_i,
  input  logic [NUM_SLOTS*SHAPE_W-1:0] master_i,
  input  logic [NUM_SLOTS-1:0]         used_i,
  output logic                         found_o,
  output logic [NUM_SLOTS-1:0]         onehot_o
);

  always_comb begin
    found_o  = 1'b0;
    onehot_o = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (!found_o && !used_i[k] && (master_i[k*SHAPE_W +: SHAPE_W] == shape_i)) begin
        onehot_o[k] = 1'b1;
        found_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/guess_grader_seq.sv
// Multi-cycle Znarly/Zood grader: one exact-match cycle, one scan cycle per slot,
// one result cycle; also tracks the round budget and won/lost status of a game.
module guess_grader_seq
  import grader_pkg::*;
#(
  parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter int SHAPE_W    = $bits(shape_t),
  parameter int MAX_ROUNDS = DEF_MAX_ROUNDS,
  localparam int CW = count_w(NUM_SLOTS),
  localparam int RW = count_w(MAX_ROUNDS),
  localparam int PW = NUM_SLOTS * SHAPE_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          startGame,
  input  logic [PW-1:0] masterPattern,
  input  logic          guessValid,
  input  logic [PW-1:0] guess,
  output logic          guessReady,
  output logic          doneGrading,
  output logic [CW-1:0] ZnarlyCount,
  output logic [CW-1:0] ZoodCount,
  output logic          GameWon,
  output logic          GameLost,
  output logic [RW-1:0] roundsLeft,
  output state_e        dbg_state
);

  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  state_e               state_q;
  logic [PW-1:0]        guess_q, master_q;
  logic [NUM_SLOTS-1:0] guess_used_q, master_used_q;
  logic [IW-1:0]        idx_q;
  logic [CW-1:0]        znarly_q, zood_q, znarly_out_q, zood_out_q;
  logic [RW-1:0]        rounds_q;
  logic                 won_q, lost_q, done_q;

  logic [NUM_SLOTS-1:0] exact_d, onehot_d;
  logic [CW-1:0]        znarly_d, zood_d;
  logic [SHAPE_W-1:0]   scan_shape_d;
  logic                 found_d, scan_hit_d, last_slot_d, accept_d;

  always_comb begin
    exact_d  = '0;
    znarly_d = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      exact_d[k] = (guess_q[k*SHAPE_W +: SHAPE_W] == master_q[k*SHAPE_W +: SHAPE_W]);
      znarly_d   = znarly_d + CW'(exact_d[k]);
    end
  end

  assign scan_shape_d = guess_q[idx_q*SHAPE_W +: SHAPE_W];

  unused_match_finder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SHAPE_W   (SHAPE_W)
  ) u_finder (
    .shape_i  (scan_shape_d),
    .master_i (master_q),
    .used_i   (master_used_q),
    .found_o  (found_d),
    .onehot_o (onehot_d)
  );

  // Slots already consumed by an exact match never take part in the scan.
  assign scan_hit_d  = !guess_used_q[idx_q] && found_d;
  assign zood_d      = zood_q + CW'(scan_hit_d);
  assign last_slot_d = (idx_q == IW'(NUM_SLOTS - 1));

  // Handshake: a guess transfers on a rising edge where guessValid and guessReady
  // are both high; guessValid at any other time is dropped, never queued.
  assign guessReady = (state_q == WAIT) && (rounds_q != '0) && !won_q && !lost_q;
  assign accept_d   = guessValid && guessReady;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      guess_q       <= '0;
      master_q      <= '0;
      guess_used_q  <= '0;
      master_used_q <= '0;
      idx_q         <= '0;
      znarly_q      <= '0;
      zood_q        <= '0;
      znarly_out_q  <= '0;
      zood_out_q    <= '0;
      rounds_q      <= '0;
      won_q         <= 1'b0;
      lost_q        <= 1'b0;
      done_q        <= 1'b0;
    end else if (startGame) begin
      state_q      <= WAIT;
      rounds_q     <= RW'(MAX_ROUNDS);
      znarly_out_q <= '0;
      zood_out_q   <= '0;
      won_q        <= 1'b0;
      lost_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        WAIT: begin
          if (accept_d) begin
            guess_q  <= guess;
            master_q <= masterPattern;
            rounds_q <= rounds_q - RW'(1);
            state_q  <= EXACT;
          end
        end
        EXACT: begin
          guess_used_q  <= exact_d;
          master_used_q <= exact_d;
          znarly_q      <= znarly_d;
          zood_q        <= '0;
          idx_q         <= '0;
          state_q       <= SCAN;
        end
        SCAN: begin
          zood_q <= zood_d;
          idx_q  <= idx_q + IW'(1);
          if (scan_hit_d) master_used_q <= master_used_q | onehot_d;
          // Results are registered on entry to DONE so they line up with the pulse.
          if (last_slot_d) begin
            znarly_out_q <= znarly_q;
            zood_out_q   <= zood_d;
            won_q        <= (znarly_q == CW'(NUM_SLOTS));
            lost_q       <= (znarly_q != CW'(NUM_SLOTS)) && (rounds_q == '0);
            done_q       <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE:    state_q <= WAIT;
        default: state_q <= state_q;
      endcase
    end
  end

  assign doneGrading = done_q;
  assign ZnarlyCount = znarly_out_q;
  assign ZoodCount   = zood_out_q;
  assign GameWon     = won_q;
  assign GameLost    = lost_q;
  assign roundsLeft  = rounds_q;
  assign dbg_state   = state_q;

endmodule
